// File: rtl/sa_pkg.sv
// Package: sa_pkg
// Shared definitions for the sa_matmul_engine systolic array: FSM state
// encoding, default geometry and the wrap/saturate accumulate helper.
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN
  } sa_state_e;

  localparam int SA_ROWS  = 8;
  localparam int SA_COLS  = 8;
  localparam int SA_DW    = 8;
  localparam int SA_ACC_W = 32;
  localparam int SA_K_MAX = 256;

  // Working width of the accumulate helper; accumulators must be narrower.
  localparam int ADD_W = 64;

  typedef struct packed {
    logic             sat;
    logic [ADD_W-1:0] sum;
  } sa_add_t;

  // Adds a sign-extended product to a sign-extended accumulator. With sat_en
  // the result is clamped to the signed acc_w range and sat flags the clamp;
  // otherwise the low acc_w bits of the sum give the wrapped result.
  function automatic sa_add_t sa_acc_add(
    input logic signed [ADD_W-1:0] acc,
    input logic signed [ADD_W-1:0] prod,
    input int unsigned             acc_w,
    input logic                    sat_en
  );
    logic signed [ADD_W:0] full;
    logic signed [ADD_W:0] one;
    logic signed [ADD_W:0] max_v;
    logic signed [ADD_W:0] min_v;
    sa_add_t               res;
    one   = {{ADD_W{1'b0}}, 1'b1};
    full  = {acc[ADD_W-1], acc} + {prod[ADD_W-1], prod};
    max_v = (one <<< (acc_w - 1)) - one;
    min_v = -(one <<< (acc_w - 1));
    res.sat = 1'b0;
    res.sum = full[ADD_W-1:0];
    if (sat_en) begin
      if (full > max_v) begin
        res.sat = 1'b1;
        res.sum = max_v[ADD_W-1:0];
      end else if (full < min_v) begin
        res.sat = 1'b1;
        res.sum = min_v[ADD_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// Module: sa_pe
// One multiply-accumulate cell of the output-stationary array. On en it adds
// a_in*b_in to its accumulator and forwards a_in right and b_in down through
// registers; clr zeroes the accumulator and the forwarding registers.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DW     = SA_DW,
  parameter int ACC_W  = SA_ACC_W,
  parameter bit SAT_EN = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [DW-1:0]    a_in,
  input  logic signed [DW-1:0]    b_in,
  output logic signed [DW-1:0]    a_out,
  output logic signed [DW-1:0]    b_out,
  output logic signed [ACC_W-1:0] acc,
  output logic                    sat
);

  logic signed [DW-1:0]    a_q, a_d;
  logic signed [DW-1:0]    b_q, b_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*DW-1:0]  prod;
  sa_add_t                 add_r;
  logic                    unused_sum_hi;

  assign prod          = a_in * b_in;
  assign add_r         = sa_acc_add(ADD_W'(acc_q), ADD_W'(prod), ACC_W, SAT_EN);
  assign unused_sum_hi = ^add_r.sum[ADD_W-1:ACC_W];

  // Next-state for operand pass-through and accumulator; hold unless enabled
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    sat   = 1'b0;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en) begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = add_r.sum[ACC_W-1:0];
      sat   = add_r.sat;
    end
  end

  // Cell registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/sa_matmul_engine.sv
// Module: sa_matmul_engine
// Output-stationary systolic matrix-multiply engine, C = A x B.
// A columns and B rows stream in over valid/ready, are skewed into a
// ROWS x COLS grid of sa_pe cells, and C leaves one row per beat.
// Build option SA_SATURATE_EN: accumulation clamps and sat_seen is a sticky
// clamp flag; without it accumulation wraps and sat_seen is tied low.
module sa_matmul_engine
  import sa_pkg::*;
#(
  parameter int  ROWS  = SA_ROWS,
  parameter int  COLS  = SA_COLS,
  parameter int  DW    = SA_DW,
  parameter int  ACC_W = SA_ACC_W,
  parameter int  K_MAX = SA_K_MAX,
  localparam int K_W   = $clog2(K_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [K_W-1:0]         k_len,
  output logic                   busy,
  output logic                   done,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ROWS*DW-1:0]     a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [COLS*DW-1:0]     b_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [COLS*ACC_W-1:0]  res_data,
  output logic                   res_last,
  output logic                   sat_seen
);

  localparam int FL_N = ROWS + COLS - 1;
  localparam int FL_W = $clog2(FL_N + 1);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef SA_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  sa_state_e        state_q, state_d;
  logic [K_W-1:0]   k_len_q, k_len_d;
  logic [K_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic             done_q, done_d;
  logic             op_ready;
  logic             advance;
  logic             clr_array;
  logic             feeding;

  logic signed [DW-1:0]    a_edge   [ROWS];
  logic signed [DW-1:0]    b_edge   [COLS];
  logic signed [DW-1:0]    a_link   [ROWS][COLS];
  logic signed [DW-1:0]    b_link   [ROWS][COLS];
  logic signed [ACC_W-1:0] acc_arr  [ROWS][COLS];
  logic [ROWS*COLS-1:0]    pe_sat;
  logic [ROWS-1:0]         unused_a_tail;
  logic [COLS-1:0]         unused_b_tail;

  // Job sequencing: launch, clear, feed beats, flush the skew, drain rows
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    done_d      = 1'b0;
    op_ready    = 1'b0;
    advance     = 1'b0;
    clr_array   = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          k_len_d = k_len;
        end
      end
      CLEAR: begin
        clr_array   = 1'b1;
        beat_cnt_d  = '0;
        flush_cnt_d = '0;
        row_d       = '0;
        state_d     = (k_len_q == '0) ? DRAIN : FEED;
      end
      FEED: begin
        op_ready = a_valid & b_valid;
        advance  = op_ready;
        if (op_ready) begin
          beat_cnt_d = beat_cnt_q + K_W'(1);
          if (beat_cnt_q == k_len_q - K_W'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        advance     = 1'b1;
        flush_cnt_d = flush_cnt_q + FL_W'(1);
        if (flush_cnt_q == FL_W'(FL_N - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
    end
  end

  assign feeding = (state_q == FEED);
  assign a_ready = op_ready;
  assign b_ready = op_ready;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  // A lane r enters r advance steps late; outside FEED zeros are injected
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_a_skew
    logic signed [DW-1:0] lane_in;
    assign lane_in = feeding ? a_data[gr*DW +: DW] : '0;
    if (gr == 0) begin : g_direct
      assign a_edge[gr] = lane_in;
    end else begin : g_delay
      logic signed [DW-1:0] sk_q [gr];
      logic signed [DW-1:0] sk_d [gr];
      // Shift the lane delay line on every array advance
      always_comb begin
        sk_d = sk_q;
        if (clr_array) begin
          for (int s = 0; s < gr; s++) sk_d[s] = '0;
        end else if (advance) begin
          sk_d[0] = lane_in;
          for (int s = 1; s < gr; s++) sk_d[s] = sk_q[s-1];
        end
      end
      // Delay line registers
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < gr; s++) sk_q[s] <= '0;
        end else begin
          sk_q <= sk_d;
        end
      end
      assign a_edge[gr] = sk_q[gr-1];
    end
  end

  // B lane c enters c advance steps late; outside FEED zeros are injected
  for (genvar gc = 0; gc < COLS; gc++) begin : g_b_skew
    logic signed [DW-1:0] lane_in;
    assign lane_in = feeding ? b_data[gc*DW +: DW] : '0;
    if (gc == 0) begin : g_direct
      assign b_edge[gc] = lane_in;
    end else begin : g_delay
      logic signed [DW-1:0] sk_q [gc];
      logic signed [DW-1:0] sk_d [gc];
      // Shift the lane delay line on every array advance
      always_comb begin
        sk_d = sk_q;
        if (clr_array) begin
          for (int s = 0; s < gc; s++) sk_d[s] = '0;
        end else if (advance) begin
          sk_d[0] = lane_in;
          for (int s = 1; s < gc; s++) sk_d[s] = sk_q[s-1];
        end
      end
      // Delay line registers
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < gc; s++) sk_q[s] <= '0;
        end else begin
          sk_q <= sk_d;
        end
      end
      assign b_edge[gc] = sk_q[gc-1];
    end
  end

  // PE grid: A flows right along rows, B flows down along columns
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic signed [DW-1:0] pe_a_in;
      logic signed [DW-1:0] pe_b_in;
      if (gc == 0) begin : g_a_from_edge
        assign pe_a_in = a_edge[gr];
      end else begin : g_a_from_left
        assign pe_a_in = a_link[gr][gc-1];
      end
      if (gr == 0) begin : g_b_from_edge
        assign pe_b_in = b_edge[gc];
      end else begin : g_b_from_above
        assign pe_b_in = b_link[gr-1][gc];
      end
      sa_pe #(
        .DW    (DW),
        .ACC_W (ACC_W),
        .SAT_EN(SAT_EN)
      ) u_pe (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (advance),
        .clr    (clr_array),
        .a_in   (pe_a_in),
        .b_in   (pe_b_in),
        .a_out  (a_link[gr][gc]),
        .b_out  (b_link[gr][gc]),
        .acc    (acc_arr[gr][gc]),
        .sat    (pe_sat[gr*COLS + gc])
      );
    end
    assign unused_a_tail[gr] = ^a_link[gr][COLS-1];
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_b_tail
    assign unused_b_tail[gc] = ^b_link[ROWS-1][gc];
  end

  // Result row mux; outputs stay zero outside DRAIN
  always_comb begin
    res_data = '0;
    res_last = 1'b0;
    if (state_q == DRAIN) begin
      res_last = (row_q == RW'(ROWS - 1));
      for (int c = 0; c < COLS; c++) res_data[c*ACC_W +: ACC_W] = acc_arr[row_q][c];
    end
  end

`ifdef SA_SATURATE_EN
  logic sat_seen_q, sat_seen_d;

  // Sticky clamp flag: cleared by a new launch, set by any clamping PE
  always_comb begin
    sat_seen_d = sat_seen_q;
    if (state_q == IDLE && start) sat_seen_d = 1'b0;
    else if (|pe_sat)             sat_seen_d = 1'b1;
  end

  // Clamp flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sat_seen_q <= 1'b0;
    else          sat_seen_q <= sat_seen_d;
  end

  assign sat_seen = sat_seen_q;
`else
  logic unused_pe_sat;
  assign unused_pe_sat = |pe_sat;
  assign sat_seen      = 1'b0;
`endif

endmodule

// File: tb/tb_sa_matmul_engine.sv
// Testbench: tb_sa_matmul_engine
// Directed tests for a 4x4, 8-bit operand, 16-bit accumulator engine.
// Expected results follow the SA_SATURATE_EN build option.
module tb_sa_matmul_engine;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 16;
  localparam int K_MAX = 16;
  localparam int K_W   = 5;

`ifdef SA_SATURATE_EN
  localparam logic signed [ACC_W-1:0] OVF_EXP = 16'sd32767;
  localparam logic                    OVF_SAT = 1'b1;
`else
  localparam logic signed [ACC_W-1:0] OVF_EXP = -16'sd2040;
  localparam logic                    OVF_SAT = 1'b0;
`endif

  logic                  clk;
  logic                  reset_n;
  logic                  start;
  logic [K_W-1:0]        k_len;
  logic                  busy;
  logic                  done;
  logic                  a_valid;
  logic                  a_ready;
  logic [ROWS*DW-1:0]    a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [COLS*DW-1:0]    b_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [COLS*ACC_W-1:0] res_data;
  logic                  res_last;
  logic                  sat_seen;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0]    mat_a [ROWS][K_MAX];
  logic signed [DW-1:0]    mat_b [K_MAX][COLS];
  logic signed [ACC_W-1:0] got   [ROWS][COLS];
  logic                    got_last [ROWS];
  int                      rows_got;
  int                      stall_viol;
  int                      ready_cycles;
  logic                    done_after;

  sa_matmul_engine #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DW   (DW),
    .ACC_W(ACC_W),
    .K_MAX(K_MAX)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .k_len    (k_len),
    .busy     (busy),
    .done     (done),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_last (res_last),
    .sat_seen (sat_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_job(input int k);
    @(posedge clk); #1;
    start = 1'b1;
    k_len = K_W'(k);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed_beats(input int n, input bit gaps);
    int j = 0;
    int guard = 0;
    bit hs;
    while (j < n && guard < 500) begin
      a_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      b_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = mat_a[r][j];
      for (int c = 0; c < COLS; c++) b_data[c*DW +: DW] = mat_b[j][c];
      #1;
      hs = a_valid & a_ready & b_valid & b_ready;
      @(posedge clk); #1;
      if (hs) j++;
      guard++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    checks++;
    if (j !== n) begin
      errors++;
      $display("[TB] FAIL feed_beats: accepted %0d beats, expected %0d", j, n);
    end
  endtask

  task automatic collect_rows(input bit gaps);
    int guard = 0;
    bit stalled = 1'b0;
    logic [COLS*ACC_W-1:0] held;
    logic held_last;
    rows_got     = 0;
    stall_viol   = 0;
    ready_cycles = 0;
    held         = '0;
    held_last    = 1'b0;
    while (rows_got < ROWS && guard < 500) begin
      res_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (a_ready || b_ready) ready_cycles++;
      if (stalled && (res_data !== held || res_last !== held_last)) stall_viol++;
      stalled   = res_valid & ~res_ready;
      held      = res_data;
      held_last = res_last;
      if (res_valid && res_ready) begin
        for (int c = 0; c < COLS; c++) got[rows_got][c] = res_data[c*ACC_W +: ACC_W];
        got_last[rows_got] = res_last;
        rows_got++;
      end
      @(posedge clk); #1;
      guard++;
    end
    res_ready  = 1'b0;
    done_after = done;
    checks++;
    if (rows_got !== ROWS) begin
      errors++;
      $display("[TB] FAIL collect_rows: received %0d rows, expected %0d", rows_got, ROWS);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b, expected 0", res_valid); end
    checks++; if (res_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_last: got %b, expected 0", res_last); end
    checks++; if (res_data !== '0) begin errors++; $display("[TB] FAIL reset_res_data: got %h, expected 0", res_data); end
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b%b, expected 00", a_ready, b_ready); end
    checks++; if (sat_seen !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat_seen: got %b, expected 0", sat_seen); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_a_ready: got %b, expected 0", a_ready); end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_identity();
    logic signed [ACC_W-1:0] exp_v;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < 4; k++) mat_a[r][k] = (r == k) ? 8'sd1 : 8'sd0;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < COLS; c++) mat_b[k][c] = DW'(k*4 + c);
    start_job(4);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL identity_busy: got %b, expected 1", busy); end
    feed_beats(4, 1'b0);
    collect_rows(1'b0);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        exp_v = ACC_W'(r*4 + c);
        checks++;
        if (got[r][c] !== exp_v) begin
          errors++;
          $display("[TB] FAIL identity r%0d c%0d: got %0d, expected %0d", r, c, got[r][c], exp_v);
        end
      end
      checks++;
      if (got_last[r] !== (r == ROWS-1)) begin
        errors++;
        $display("[TB] FAIL identity_last r%0d: got %b, expected %b", r, got_last[r], (r == ROWS-1));
      end
    end
    checks++; if (done_after !== 1'b1) begin errors++; $display("[TB] FAIL identity_done: got %b, expected 1", done_after); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL identity_done_pulse: got %b, expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL identity_idle: got busy %b, expected 0", busy); end
  endtask

  task automatic test_signed();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < 2; k++) mat_a[r][k] = -8'sd128;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < COLS; c++) mat_b[k][c] = 8'sd127;
    start_job(2);
    feed_beats(2, 1'b0);
    collect_rows(1'b0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (got[r][c] !== -16'sd32512) begin
          errors++;
          $display("[TB] FAIL signed r%0d c%0d: got %0d, expected -32512", r, c, got[r][c]);
        end
      end
    checks++; if (sat_seen !== 1'b0) begin errors++; $display("[TB] FAIL signed_sat_seen: got %b, expected 0", sat_seen); end
  endtask

  task automatic test_backpressure();
    int sum;
    logic signed [ACC_W-1:0] exp_v;
    for (int k = 0; k < K_MAX; k++) begin
      for (int r = 0; r < ROWS; r++) mat_a[r][k] = DW'(((r*5 + k*3) % 11) - 5);
      for (int c = 0; c < COLS; c++) mat_b[k][c] = DW'(((k*7 + c*2) % 13) - 6);
    end
    start_job(K_MAX);
    feed_beats(K_MAX, 1'b1);
    collect_rows(1'b1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        sum = 0;
        for (int k = 0; k < K_MAX; k++) sum += int'(mat_a[r][k]) * int'(mat_b[k][c]);
        exp_v = ACC_W'(sum);
        checks++;
        if (got[r][c] !== exp_v) begin
          errors++;
          $display("[TB] FAIL backpressure r%0d c%0d: got %0d, expected %0d", r, c, got[r][c], exp_v);
        end
      end
    checks++; if (stall_viol !== 0) begin errors++; $display("[TB] FAIL backpressure_stable: %0d changes while stalled, expected 0", stall_viol); end
    checks++; if (done_after !== 1'b1) begin errors++; $display("[TB] FAIL backpressure_done: got %b, expected 1", done_after); end
  endtask

  task automatic test_zero_k();
    start_job(0);
    a_valid = 1'b1;
    b_valid = 1'b1;
    collect_rows(1'b0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (got[r][c] !== '0) begin
          errors++;
          $display("[TB] FAIL zero_k r%0d c%0d: got %0d, expected 0", r, c, got[r][c]);
        end
      end
    checks++; if (ready_cycles !== 0) begin errors++; $display("[TB] FAIL zero_k_ready: ready high %0d cycles, expected 0", ready_cycles); end
    checks++; if (got_last[ROWS-1] !== 1'b1) begin errors++; $display("[TB] FAIL zero_k_last: got %b, expected 1", got_last[ROWS-1]); end
    checks++; if (done_after !== 1'b1) begin errors++; $display("[TB] FAIL zero_k_done: got %b, expected 1", done_after); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < ROWS; r++) mat_a[r][k] = 8'sd127;
      for (int c = 0; c < COLS; c++) mat_b[k][c] = 8'sd127;
    end
    start_job(8);
    feed_beats(8, 1'b0);
    collect_rows(1'b0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (got[r][c] !== OVF_EXP) begin
          errors++;
          $display("[TB] FAIL overflow r%0d c%0d: got %0d, expected %0d", r, c, got[r][c], OVF_EXP);
        end
      end
    checks++; if (sat_seen !== OVF_SAT) begin errors++; $display("[TB] FAIL overflow_sat_seen: got %b, expected %b", sat_seen, OVF_SAT); end
  endtask

  task automatic test_reset_mid_feed();
    logic signed [ACC_W-1:0] exp_v;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < 4; k++) mat_a[r][k] = (r == k) ? 8'sd2 : 8'sd0;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < COLS; c++) mat_b[k][c] = DW'(k*4 + c);
    start_job(4);
    feed_beats(2, 1'b0);
    a_valid = 1'b1;
    b_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || a_ready !== 1'b0 || res_data !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: busy %b res_valid %b a_ready %b res_data %h, expected all 0", busy, res_valid, a_ready, res_data);
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || sat_seen !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: done %b sat_seen %b, expected 0 0", done, sat_seen); end
    reset_n = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_after: done %b busy %b, expected 0 0", done, busy); end
    start_job(4);
    feed_beats(4, 1'b0);
    collect_rows(1'b0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp_v = ACC_W'(2 * (r*4 + c));
        checks++;
        if (got[r][c] !== exp_v) begin
          errors++;
          $display("[TB] FAIL midreset_job r%0d c%0d: got %0d, expected %0d", r, c, got[r][c], exp_v);
        end
      end
    checks++; if (done_after !== 1'b1) begin errors++; $display("[TB] FAIL midreset_job_done: got %b, expected 1", done_after); end
    checks++; if (sat_seen !== 1'b0) begin errors++; $display("[TB] FAIL midreset_job_sat: got %b, expected 0", sat_seen); end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    k_len     = '0;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = '0;
    b_data    = '0;
    res_ready = 1'b0;
    $display("[TB] sa_matmul_engine directed tests starting");
    test_reset();
    test_identity();
    test_signed();
    test_backpressure();
    test_zero_k();
    test_overflow();
    test_reset_mid_feed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
